i2c_txn_arbiter: RTL

Shares the single i2c_com engine between two requesters: port 0 is the codec power-up config sequencer, port 1 is runtime volume/mute updates.
Arbitrates round-robin and presents one 24-bit frame at a time (device address + 16-bit register word).
Runs the start/tr_end handshake, retries on NACK, applies a transfer timeout and enforces an inter-frame gap.
Runs entirely on the system clock; engine status signals are synchronised internally.

---
 rtl/i2c_txn_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_txn_arbiter : round-robin sharing of one i2c_com engine by two requesters
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int GAP_CYCLES     = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic [23:0] data0_i,
  input  logic        req1_i,
  input  logic [23:0] data1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic        busy_o,
  output logic        eng_start_o,
  output logic [23:0] eng_data_o,
  input  logic        eng_tr_end_i,
  input  logic        eng_ack_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_END = 2'd1,
    WAIT_CLR = 2'd2,
    GAP      = 2'd3
  } state_e;

  state_e        state_q;
  logic          tr_meta_q, tr_s_q;
  logic          ack_meta_q, ack_s_q;
  logic          gnt0_q, gnt1_q;
  logic          done0_q, done1_q;
  logic          err0_q, err1_q;
  logic          busy_q;
  logic          eng_start_q;
  logic [23:0]   eng_data_q;
  logic          last_q;
  logic          retry_pend_q;
  logic [RW-1:0] retry_cnt_q;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;

  logic          pick1_d;
  logic          timeout_hit;
  logic          retry_ok;
  logic          gap_done;

  // last_q names the port served most recently; on contention the other one wins
  always_comb begin
    pick1_d = req1_i;
    if (req0_i && req1_i) begin
      pick1_d = ~last_q;
    end
  end

  assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign retry_ok    = (retry_cnt_q < RW'(MAX_RETRY));
  assign gap_done    = (gap_q == GW'(GAP_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      tr_meta_q    <= 1'b0;
      tr_s_q       <= 1'b0;
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      busy_q       <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_data_q   <= '0;
      last_q       <= 1'b1;
      retry_pend_q <= 1'b0;
      retry_cnt_q  <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
    end else begin
      tr_meta_q  <= eng_tr_end_i;
      tr_s_q     <= tr_meta_q;
      ack_meta_q <= eng_ack_i;
      ack_s_q    <= ack_meta_q;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            gnt0_q       <= ~pick1_d;
            gnt1_q       <= pick1_d;
            last_q       <= pick1_d;
            eng_data_q   <= pick1_d ? data1_i : data0_i;
            eng_start_q  <= 1'b1;
            timer_q      <= '0;
            retry_pend_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= WAIT_END;
          end
        end

        WAIT_END: begin
          timer_q <= timer_q + TW'(1);
          if (tr_s_q) begin
            eng_start_q <= 1'b0;
            state_q     <= WAIT_CLR;
            if (!ack_s_q) begin
              done0_q <= gnt0_q;
              done1_q <= gnt1_q;
            end else if (retry_ok) begin
              retry_cnt_q  <= retry_cnt_q + RW'(1);
              retry_pend_q <= 1'b1;
            end else begin
              err0_q <= gnt0_q;
              err1_q <= gnt1_q;
            end
          end else if (timeout_hit) begin
            eng_start_q  <= 1'b0;
            err0_q       <= gnt0_q;
            err1_q       <= gnt1_q;
            retry_pend_q <= 1'b0;
            gap_q        <= '0;
            state_q      <= GAP;
          end
        end

        WAIT_CLR: begin
          timer_q <= timer_q + TW'(1);
          if (!tr_s_q) begin
            gap_q   <= '0;
            state_q <= GAP;
          end else if (timeout_hit) begin
            // Only a pending retry is still unreported; an ACKed or failed frame already pulsed
            err0_q       <= gnt0_q & retry_pend_q;
            err1_q       <= gnt1_q & retry_pend_q;
            retry_pend_q <= 1'b0;
            gap_q        <= '0;
            state_q      <= GAP;
          end
        end

        GAP: begin
          if (gap_done) begin
            if (retry_pend_q) begin
              eng_start_q  <= 1'b1;
              timer_q      <= '0;
              retry_pend_q <= 1'b0;
              state_q      <= WAIT_END;
            end else begin
              gnt0_q      <= 1'b0;
              gnt1_q      <= 1'b0;
              retry_cnt_q <= '0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
  assign busy_o      = busy_q;
  assign eng_start_o = eng_start_q;
  assign eng_data_o  = eng_data_q;

endmodule
`default_nettype wire
